dbg_host_bridge: RTL and testbench
==================================

// Module: dbg_host_bridge
// PURPOSE
//  Host-side initiator for the debug port (cmd/addr/data/ready) served by dbg_module.
//  Assembles 9-byte command frames from a byte stream (e.g. a UART RX), drives the debug port,
//  waits for completion, and returns a 5-byte response frame on a byte stream (e.g. a UART TX).
//  Sits between the host link PHY and the core wrapper's debug inputs.
// PARAMETERS
//  WAIT_TIMEOUT   1024  max cycles in WAIT for dbg_ready_i before abort (>=2)
//  FRAME_TIMEOUT  65535 max idle cycles between bytes of one frame before resync (>=2)
// PORTS
//  clk          in   1   clock, all logic rising-edge
//  rst_i        in   1   asynchronous, active-high reset
//  rx_data_i    in   8   incoming host byte
//  rx_valid_i   in   1   rx_data_i valid
//  rx_ready_o   out  1   bridge accepts byte; transfer = rx_valid_i & rx_ready_o
//  tx_data_o    out  8   outgoing response byte
//  tx_valid_o   out  1   tx_data_o valid
//  tx_ready_i   in   1   sink accepts byte; transfer = tx_valid_o & tx_ready_i
//  dbg_cmd_o    out  8   debug command; 8'h00 = NOP
//  dbg_addr_o   out  32  debug address
//  dbg_data_o   out  32  debug write data
//  dbg_data_i   in   32  debug read data, valid when dbg_ready_i=1
//  dbg_ready_i  in   1   debug responder done
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; rx_ready_o=1; tx_valid_o=0; tx_data_o=0; dbg_cmd_o=0;
//   dbg_addr_o=0; dbg_data_o=0; all counters 0. Any in-flight frame or response is dropped.
//  Frame in: byte0=cmd, bytes1-4=addr LSB first, bytes5-8=data LSB first.
//  Response out: status byte (8'h00 ok, 8'hFF timeout), then 4 bytes of read data LSB first.
//  States:
//   IDLE  rx_ready_o=1. Byte 8'h00 is discarded (resync filler, no response). Any other byte is
//         latched as cmd -> ADDR, byte counter=0.
//   ADDR  rx_ready_o=1. Each byte shifts into addr[8*cnt+:8]; after 4th -> DATA, cnt=0.
//   DATA  as ADDR into data; after 4th byte -> ISSUE.
//   ISSUE one cycle: dbg_cmd_o/addr/data driven from latched frame; dbg_ready_i ignored -> WAIT.
//   WAIT  dbg_cmd_o held. dbg_ready_i=1: capture dbg_data_i, status=00 -> RESP.
//         Timer reaches WAIT_TIMEOUT: result=32'hDEAD_BEEF, status=FF -> RESP.
//         dbg_ready_i and timeout in same cycle: ready wins (status 00).
//   RESP  dbg_cmd_o=0 from first RESP cycle. tx_valid_o=1, send 5 bytes; tx_data_o stable while
//         tx_valid_o & ~tx_ready_i. After 5th transfer -> IDLE with tx_valid_o=0 next cycle.
//  rx_ready_o=0 in ISSUE/WAIT/RESP (byte stream back-pressured, nothing dropped).
//  dbg_addr_o/dbg_data_o hold last issued values outside ISSUE/WAIT.
//  Frame timeout: in ADDR/DATA, idle counter increments each cycle without an rx transfer, clears
//   on transfer; reaching FRAME_TIMEOUT -> IDLE, partial frame discarded, no response.
//  Wait timer and idle counter are saturating-free: cleared on state entry, width $clog2(max+1).
//  Throughput: one rx byte per cycle in IDLE/ADDR/DATA; one tx byte per cycle in RESP.
//  Min frame latency: last rx byte -> first tx_valid_o = 3 cycles when dbg_ready_i already high.
// TESTING
//  1 Frame 01 | 10 00 00 00 | EF BE AD DE, dbg_ready_i=1 after 3 WAIT cycles with dbg_data_i=
//    32'h1234_5678 -> dbg_cmd_o=01, addr=32'h10, data=32'hDEADBEEF; tx bytes 00 78 56 34 12.
//  2 Same frame, dbg_ready_i never asserted, WAIT_TIMEOUT=16 -> after 16 WAIT cycles tx bytes
//    FF EF BE AD DE; dbg_cmd_o returns to 00.
//  3 Leading bytes 00 00 then valid frame -> zeros ignored, exactly one 5-byte response.
//  4 3 bytes of frame then idle > FRAME_TIMEOUT (=8) then full frame -> only second frame issued.
//  5 tx_ready_i toggling 1010..., rx_valid_i held high with next frame during RESP -> tx_data_o
//    stable while stalled, rx_ready_o=0 until IDLE, next frame then accepted intact.
//  6 rst_i pulsed mid-WAIT -> all outputs at reset values within same cycle; next frame works.

Source files
------------

// File: rtl/dbg_host_bridge.sv
// dbg_host_bridge
//   Host-side initiator for the debug port. Bytes arriving on the rx stream
//   (for example from a UART receiver) are assembled into 9-byte command frames:
//     byte0 = cmd, bytes1-4 = addr (LSB first), bytes5-8 = data (LSB first).
//   Each frame is issued on the debug port. The bridge then waits for
//   dbg_ready_i, or gives up after WAIT_TIMEOUT cycles, and returns a 5-byte
//   response on the tx stream:
//     status (00 ok / FF timeout), then 4 bytes of read data (LSB first).
//   A 00 byte between frames is treated as resync filler and ignored. A frame
//   that stalls for FRAME_TIMEOUT idle cycles is discarded.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst_i        asynchronous active-high reset
//   rx_data_i    incoming host byte
//   rx_valid_i   rx_data_i valid
//   rx_ready_o   byte accepted when rx_valid_i & rx_ready_o
//   tx_data_o    outgoing response byte
//   tx_valid_o   tx_data_o valid
//   tx_ready_i   sink accepts byte when tx_valid_o & tx_ready_i
//   dbg_cmd_o    debug command, 00 = NOP
//   dbg_addr_o   debug address
//   dbg_data_o   debug write data
//   dbg_data_i   debug read data, valid with dbg_ready_i
//   dbg_ready_i  debug responder done
module dbg_host_bridge #(
  parameter int WAIT_TIMEOUT  = 1024,
  parameter int FRAME_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i
);

  localparam int WT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [7:0]      cmd_q;
  logic [31:0]     addr_q;
  logic [31:0]     data_q;
  logic [31:0]     last_addr_q;
  logic [31:0]     last_data_q;
  logic [31:0]     result_q;
  logic            timeout_q;
  logic [1:0]      byte_cnt_q;
  logic [2:0]      tx_idx_q;
  logic [WT_W-1:0] wait_cnt_q;
  logic [FT_W-1:0] idle_cnt_q;

  logic rx_xfer;
  logic tx_xfer;
  logic wait_expire;
  logic idle_expire;

  assign rx_xfer = rx_valid_i & rx_ready_o;
  assign tx_xfer = tx_valid_o & tx_ready_i;

  // The counters start at 0 on state entry, so the value N-1 on a cycle that
  // still qualifies means this is the N-th such cycle.
  assign wait_expire = (wait_cnt_q == WT_W'(WAIT_TIMEOUT - 1));
  assign idle_expire = (idle_cnt_q == FT_W'(FRAME_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rx_xfer && (rx_data_i != 8'h00)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (rx_xfer) begin
          if (byte_cnt_q == 2'd3) state_d = S_DATA;
        end else if (idle_expire) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_xfer) begin
          if (byte_cnt_q == 2'd3) state_d = S_ISSUE;
        end else if (idle_expire) begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      // A ready response takes priority over a timeout that expires in the same cycle.
      S_WAIT: begin
        if (dbg_ready_i || wait_expire) state_d = S_RESP;
      end
      S_RESP: begin
        if (tx_xfer && (tx_idx_q == 3'd4)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame assembly, counters and response capture
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      result_q    <= '0;
      timeout_q   <= 1'b0;
      byte_cnt_q  <= '0;
      tx_idx_q    <= '0;
      wait_cnt_q  <= '0;
      idle_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          byte_cnt_q <= '0;
          idle_cnt_q <= '0;
          wait_cnt_q <= '0;
          if (rx_xfer && (rx_data_i != 8'h00)) cmd_q <= rx_data_i;
        end
        // byte_cnt_q wraps 3 -> 0, which is exactly the start value for the next field.
        S_ADDR: begin
          if (rx_xfer) begin
            addr_q[8*byte_cnt_q +: 8] <= rx_data_i;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + FT_W'(1);
          end
        end
        S_DATA: begin
          if (rx_xfer) begin
            data_q[8*byte_cnt_q +: 8] <= rx_data_i;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + FT_W'(1);
          end
        end
        // The issued address and data must survive the next frame being shifted in.
        S_ISSUE: begin
          last_addr_q <= addr_q;
          last_data_q <= data_q;
          wait_cnt_q  <= '0;
          tx_idx_q    <= '0;
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + WT_W'(1);
          tx_idx_q   <= '0;
          if (dbg_ready_i) begin
            result_q  <= dbg_data_i;
            timeout_q <= 1'b0;
          end else if (wait_expire) begin
            result_q  <= 32'hDEAD_BEEF;
            timeout_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (tx_xfer) tx_idx_q <= tx_idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so that an asynchronous reset is visible at once.
  always_comb begin
    rx_ready_o = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    tx_valid_o = (state_q == S_RESP);
    tx_data_o  = 8'h00;
    if (state_q == S_RESP) begin
      case (tx_idx_q)
        3'd0:    tx_data_o = {8{timeout_q}};
        3'd1:    tx_data_o = result_q[7:0];
        3'd2:    tx_data_o = result_q[15:8];
        3'd3:    tx_data_o = result_q[23:16];
        3'd4:    tx_data_o = result_q[31:24];
        default: tx_data_o = 8'h00;
      endcase
    end
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      dbg_cmd_o  = cmd_q;
      dbg_addr_o = addr_q;
      dbg_data_o = data_q;
    end else begin
      dbg_cmd_o  = 8'h00;
      dbg_addr_o = last_addr_q;
      dbg_data_o = last_data_q;
    end
  end

endmodule

// File: tb/tb_dbg_host_bridge.sv
module tb_dbg_host_bridge;

  localparam int WT = 16;
  localparam int FT = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic [31:0] dbg_data_i = 32'h0;
  logic        dbg_ready_i = 1'b0;

  int total = 0;
  int bad   = 0;

  // Observations gathered by the driver tasks
  bit          o_ok;
  logic [7:0]  o_cmd, o_cmd_after;
  logic [31:0] o_addr, o_data;
  logic [39:0] o_rsp;
  int          o_wcyc, o_cmd_bad, o_n, o_stall_bad, o_rxr_bad;

  dbg_host_bridge #(.WAIT_TIMEOUT(WT), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o),
    .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: response frame (status byte in [7:0]) and WAIT duration.
  function automatic logic [39:0] model_rsp(int delay, logic [31:0] rdata);
    if (delay < WT) return {rdata, 8'h00};
    return {32'hDEAD_BEEF, 8'hFF};
  endfunction

  function automatic int model_wait(int delay);
    return (delay < WT) ? delay + 1 : WT;
  endfunction

  function automatic logic [71:0] rand_frame();
    logic [7:0] c;
    c = 8'($urandom_range(1, 255));
    return {32'($urandom()), 32'($urandom()), c};
  endfunction

  // All driver tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rx_ready_o) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] f, input int first, output bit ok);
    bit b;
    ok = 1'b1;
    for (int i = first; i < 9; i++) begin
      send_byte(f[8*i +: 8], b);
      if (!b) ok = 1'b0;
    end
  endtask

  // Called in the ISSUE cycle; the responder answers on WAIT cycle delay+1.
  task automatic serve(input logic [7:0] cmd, input int delay, input logic [31:0] rdata);
    o_cmd     = dbg_cmd_o;
    o_addr    = dbg_addr_o;
    o_data    = dbg_data_o;
    o_wcyc    = 0;
    o_cmd_bad = 0;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      if (tx_valid_o) break;
      o_wcyc++;
      if (dbg_cmd_o !== cmd) o_cmd_bad++;
      dbg_ready_i = (o_wcyc == delay + 1);
      dbg_data_i  = (o_wcyc == delay + 1) ? rdata : $urandom();
      @(negedge clk);
    end
    dbg_ready_i = 1'b0;
    o_cmd_after = dbg_cmd_o;
  endtask

  // mode 0: always ready, 1: ready toggles 1010..., 2: random ready
  task automatic collect(input int mode);
    bit         stalled, ph;
    logic [7:0] prev;
    o_rsp = '0; o_n = 0; o_stall_bad = 0; o_rxr_bad = 0;
    stalled = 1'b0; ph = 1'b1; prev = 8'h00;
    for (int i = 0; i < 200 && o_n < 5; i++) begin
      if (!tx_valid_o) break;
      if (stalled && (tx_data_o !== prev)) o_stall_bad++;
      if (rx_ready_o) o_rxr_bad++;
      tx_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
      ph = ~ph;
      if (tx_ready_i) begin
        o_rsp[8*o_n +: 8] = tx_data_o;
        o_n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      prev = tx_data_o;
      @(negedge clk);
    end
    tx_ready_i = 1'b0;
  endtask

  task automatic txn(input logic [71:0] f, input int first, input int delay,
                     input logic [31:0] rdata, input int mode);
    send_frame(f, first, o_ok);
    serve(f[7:0], delay, rdata);
    collect(mode);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if ({rx_ready_o, tx_valid_o, tx_data_o, dbg_cmd_o} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin bad++; $display("FAIL reset_ctrl got rdy=%b tv=%b td=%h cmd=%h want 1 0 00 00", rx_ready_o, tx_valid_o, tx_data_o, dbg_cmd_o); end
    total++; if ({dbg_addr_o, dbg_data_o} !== 64'h0) begin bad++; $display("FAIL reset_dbg got addr=%h data=%h want 0 0", dbg_addr_o, dbg_data_o); end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [71:0] f;
    f = {32'hDEAD_BEEF, 32'h0000_0010, 8'h01};
    txn(f, 0, 3, 32'h1234_5678, 0);
    total++; if (!o_ok || {o_data, o_addr, o_cmd} !== f) begin bad++; $display("FAIL basic_issue got ok=%b %h %h %h want %h", o_ok, o_data, o_addr, o_cmd, f); end
    total++; if (o_wcyc != model_wait(3) || o_cmd_bad != 0) begin bad++; $display("FAIL basic_wait got %0d cycles (%0d cmd drops) want %0d", o_wcyc, o_cmd_bad, model_wait(3)); end
    total++; if (o_cmd_after !== 8'h00) begin bad++; $display("FAIL basic_cmd_resp got %h want 00", o_cmd_after); end
    total++; if (o_n != 5 || o_rsp !== 40'h12_3456_7800) begin bad++; $display("FAIL basic_rsp got n=%0d %h want 5 1234567800", o_n, o_rsp); end
    total++; if (tx_valid_o !== 1'b0 || rx_ready_o !== 1'b1) begin bad++; $display("FAIL basic_idle got tv=%b rdy=%b want 0 1", tx_valid_o, rx_ready_o); end
    total++; if (dbg_addr_o !== 32'h10 || dbg_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_hold got %h %h want 00000010 deadbeef", dbg_addr_o, dbg_data_o); end
    // Minimum latency: responder already ready, so one WAIT cycle.
    f = rand_frame();
    txn(f, 0, 0, 32'hA5A5_0F0F, 0);
    total++; if (o_wcyc != 1 || o_rsp !== model_rsp(0, 32'hA5A5_0F0F)) begin bad++; $display("FAIL latency got %0d cycles rsp %h want 1 %h", o_wcyc, o_rsp, model_rsp(0, 32'hA5A5_0F0F)); end
  endtask

  task automatic test_timeout();
    logic [71:0] f;
    f = {32'hDEAD_BEEF, 32'h0000_0010, 8'h01};
    txn(f, 0, 1000, 32'h0, 0);
    total++; if (o_wcyc != WT) begin bad++; $display("FAIL tmo_wait got %0d want %0d", o_wcyc, WT); end
    total++; if (o_n != 5 || o_rsp !== 40'hDE_ADBE_EFFF) begin bad++; $display("FAIL tmo_rsp got n=%0d %h want 5 deadbeefff", o_n, o_rsp); end
    total++; if (o_cmd_after !== 8'h00 || dbg_cmd_o !== 8'h00) begin bad++; $display("FAIL tmo_cmd got %h %h want 00", o_cmd_after, dbg_cmd_o); end
    // Ready arrives on the very cycle the timer expires: ready wins.
    f = rand_frame();
    txn(f, 0, WT - 1, 32'h0BAD_F00D, 0);
    total++; if (o_wcyc != WT || o_rsp !== model_rsp(WT - 1, 32'h0BAD_F00D)) begin bad++; $display("FAIL tmo_tie got %0d %h want %0d %h", o_wcyc, o_rsp, WT, model_rsp(WT - 1, 32'h0BAD_F00D)); end
  endtask

  task automatic test_random();
    logic [71:0] f;
    logic [31:0] rd;
    int          d, m;
    for (int k = 0; k < 8; k++) begin
      f  = rand_frame();
      rd = $urandom();
      d  = $urandom_range(0, WT + 3);
      m  = $urandom_range(0, 2);
      txn(f, 0, d, rd, m);
      total++; if (!o_ok || {o_data, o_addr, o_cmd} !== f || o_cmd_bad != 0) begin bad++; $display("FAIL rand%0d_issue got %h %h %h want %h", k, o_data, o_addr, o_cmd, f); end
      total++; if (o_wcyc != model_wait(d)) begin bad++; $display("FAIL rand%0d_wait got %0d want %0d", k, o_wcyc, model_wait(d)); end
      total++; if (o_n != 5 || o_rsp !== model_rsp(d, rd) || o_stall_bad != 0) begin bad++; $display("FAIL rand%0d_rsp got n=%0d %h stall=%0d want %h", k, o_n, o_rsp, o_stall_bad, model_rsp(d, rd)); end
    end
  endtask

  task automatic test_resync();
    logic [71:0] f;
    bit          b;
    int          extra;
    f = rand_frame();
    send_byte(8'h00, b);
    send_byte(8'h00, b);
    txn(f, 0, 2, 32'h5566_7788, 0);
    total++; if ({o_data, o_addr, o_cmd} !== f) begin bad++; $display("FAIL resync_issue got %h %h %h want %h", o_data, o_addr, o_cmd, f); end
    total++; if (o_n != 5 || o_rsp !== model_rsp(2, 32'h5566_7788)) begin bad++; $display("FAIL resync_rsp got %h want %h", o_rsp, model_rsp(2, 32'h5566_7788)); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid_o || dbg_cmd_o != 8'h00) extra++;
      @(negedge clk);
    end
    total++; if (extra != 0) begin bad++; $display("FAIL resync_extra got %0d busy cycles want 0", extra); end
  endtask

  task automatic test_frame_timeout();
    logic [71:0] fa, fb;
    bit          b;
    fa = rand_frame();
    fb = rand_frame();
    for (int i = 0; i < 3; i++) send_byte(fa[8*i +: 8], b);
    repeat (FT + 3) @(negedge clk);
    total++; if (dbg_cmd_o !== 8'h00 || rx_ready_o !== 1'b1) begin bad++; $display("FAIL ftmo_idle got cmd=%h rdy=%b want 00 1", dbg_cmd_o, rx_ready_o); end
    txn(fb, 0, 1, 32'h1357_9BDF, 2);
    total++; if ({o_data, o_addr, o_cmd} !== fb) begin bad++; $display("FAIL ftmo_issue got %h %h %h want %h", o_data, o_addr, o_cmd, fb); end
    total++; if (o_rsp !== model_rsp(1, 32'h1357_9BDF)) begin bad++; $display("FAIL ftmo_rsp got %h want %h", o_rsp, model_rsp(1, 32'h1357_9BDF)); end
    // A gap one cycle short of the limit keeps the partial frame.
    fa = rand_frame();
    for (int i = 0; i < 3; i++) send_byte(fa[8*i +: 8], b);
    repeat (FT - 1) @(negedge clk);
    txn(fa, 3, 0, 32'h2468_ACE0, 0);
    total++; if ({o_data, o_addr, o_cmd} !== fa) begin bad++; $display("FAIL ftmo_edge got %h %h %h want %h", o_data, o_addr, o_cmd, fa); end
  endtask

  task automatic test_back_to_back();
    logic [71:0] f1, f2;
    f1 = rand_frame();
    f2 = rand_frame();
    send_frame(f1, 0, o_ok);
    serve(f1[7:0], 2, 32'hCAFE_0001);
    rx_data_i  = f2[7:0];
    rx_valid_i = 1'b1;
    collect(1);
    total++; if (o_n != 5 || o_rsp !== model_rsp(2, 32'hCAFE_0001)) begin bad++; $display("FAIL b2b_rsp1 got n=%0d %h want %h", o_n, o_rsp, model_rsp(2, 32'hCAFE_0001)); end
    total++; if (o_stall_bad != 0) begin bad++; $display("FAIL b2b_stall got %0d changes while stalled want 0", o_stall_bad); end
    total++; if (o_rxr_bad != 0) begin bad++; $display("FAIL b2b_rx_ready got %0d ready cycles in RESP want 0", o_rxr_bad); end
    txn(f2, 0, 4, 32'hCAFE_0002, 1);
    total++; if ({o_data, o_addr, o_cmd} !== f2) begin bad++; $display("FAIL b2b_issue2 got %h %h %h want %h", o_data, o_addr, o_cmd, f2); end
    total++; if (o_rsp !== model_rsp(4, 32'hCAFE_0002)) begin bad++; $display("FAIL b2b_rsp2 got %h want %h", o_rsp, model_rsp(4, 32'hCAFE_0002)); end
  endtask

  task automatic test_reset_mid_wait();
    logic [71:0] f;
    f = rand_frame();
    f[39:8] = f[39:8] | 32'h1;
    send_frame(f, 0, o_ok);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    #1;
    total++; if ({rx_ready_o, tx_valid_o, tx_data_o, dbg_cmd_o} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin bad++; $display("FAIL rstw_ctrl got rdy=%b tv=%b td=%h cmd=%h want 1 0 00 00", rx_ready_o, tx_valid_o, tx_data_o, dbg_cmd_o); end
    total++; if ({dbg_addr_o, dbg_data_o} !== 64'h0) begin bad++; $display("FAIL rstw_dbg got addr=%h data=%h want 0 0", dbg_addr_o, dbg_data_o); end
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    f = rand_frame();
    txn(f, 0, 1, 32'h7777_1111, 0);
    total++; if ({o_data, o_addr, o_cmd} !== f || o_rsp !== model_rsp(1, 32'h7777_1111)) begin bad++; $display("FAIL rstw_after got %h %h %h rsp %h want %h %h", o_data, o_addr, o_cmd, o_rsp, f, model_rsp(1, 32'h7777_1111)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_random();
    test_resync();
    test_frame_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
